urisc_mem_arbiter: RTL

Shares the single-port RAM of the SUBLEQ datapath between the CPU control FSM and an external debug/loader port (program load, memory inspection). Sits between the processor's MAR/MDR path and the RAM block. Round-robin arbitration per transaction. Optional CPU lock keeps the read-A/read-B/write-B sequence of a SUBLEQ instruction atomic.

---
 rtl/urisc_pkg.sv | 19 +
 rtl/urisc_rr_pick.sv | 24 ++
 rtl/urisc_mem_arbiter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/urisc_pkg.sv
// Shared types and default widths for the SUBLEQ processor, its datapath and
// the RAM arbiter.
package urisc_pkg;

  localparam int URISC_ADDR_W = 8;
  localparam int URISC_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_e;

endpackage

// File: rtl/urisc_rr_pick.sv
// Two-way round-robin picker for CPU / debug port; lock forces the CPU side.
module urisc_rr_pick
  import urisc_pkg::*;
(
  input  logic [1:0] reqs_i,        // [0]=CPU, [1]=debug
  input  logic       last_owner_i,
  input  logic       lock_i,
  output logic       grant_valid_o,
  output logic       grant_owner_o
);

  always_comb begin
    grant_valid_o = 1'b0;
    grant_owner_o = OWN_CPU;
    if (reqs_i[0] && (lock_i || !reqs_i[1] || (last_owner_i == OWN_DBG))) begin
      grant_valid_o = 1'b1;
      grant_owner_o = OWN_CPU;
    end else if (reqs_i[1] && !lock_i) begin
      grant_valid_o = 1'b1;
      grant_owner_o = OWN_DBG;
    end
  end

endmodule

// File: rtl/urisc_mem_arbiter.sv
// Shares the single-port SUBLEQ RAM between the CPU control FSM and the
// debug/loader port: IDLE -> ISSUE -> RESP, round-robin, optional CPU lock.
module urisc_mem_arbiter
  import urisc_pkg::*;
#(
  parameter int ADDR_W = URISC_ADDR_W,
  parameter int DATA_W = URISC_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic              cpu_lock,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;   // last owner == owner of in-flight txn
  logic              lock_hold_q, lock_hold_d;
  logic              we_q, we_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;

  logic       in_resp;
  logic       arb_en;
  logic [1:0] reqs;
  logic       pick_lock;
  logic       grant_valid;
  logic       grant_owner;

  assign in_resp = (state_q == RESP);
  assign arb_en  = (state_q == IDLE) || in_resp;

  // The owner being acked still holds req high; that is not a new request yet.
  assign reqs[0]   = cpu_req && !(in_resp && (owner_q == OWN_CPU));
  assign reqs[1]   = dbg_req && !(in_resp && (owner_q == OWN_DBG));
  assign pick_lock = cpu_lock && (lock_hold_q || reqs[0]);

  urisc_rr_pick u_pick (
    .reqs_i        (reqs),
    .last_owner_i  (owner_q),
    .lock_i        (pick_lock),
    .grant_valid_o (grant_valid),
    .grant_owner_o (grant_owner)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    lock_hold_d = lock_hold_q;
    we_d        = we_q;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;

    case (state_q)
      ISSUE:   state_d = RESP;
      default: state_d = IDLE;
    endcase

    if (in_resp && !we_q) begin
      if (owner_q == OWN_CPU) cpu_rdata_d = ram_rdata;
      else                    dbg_rdata_d = ram_rdata;
    end

    if (arb_en) begin
      if (!cpu_lock) lock_hold_d = 1'b0;
      if (grant_valid) begin
        state_d = ISSUE;
        if (grant_owner == OWN_CPU) begin
          owner_d     = OWN_CPU;
          we_d        = cpu_we;
          ram_we_d    = cpu_we;
          ram_addr_d  = cpu_addr;
          ram_wdata_d = cpu_wdata;
          if (cpu_lock) lock_hold_d = 1'b1;
        end else begin
          owner_d     = OWN_DBG;
          we_d        = dbg_we;
          ram_we_d    = dbg_we;
          ram_addr_d  = dbg_addr;
          ram_wdata_d = dbg_wdata;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_DBG;
      lock_hold_q <= 1'b0;
      we_q        <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      lock_hold_q <= lock_hold_d;
      we_q        <= we_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  // A reset arriving mid-ISSUE must not let the dropped write reach the RAM.
  assign ram_we    = ram_we_q && reset;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign busy      = (state_q != IDLE);
  assign cpu_ack   = in_resp && (owner_q == OWN_CPU);
  assign dbg_ack   = in_resp && (owner_q == OWN_DBG);
  assign cpu_rdata = (cpu_ack && !we_q) ? ram_rdata : cpu_rdata_q;
  assign dbg_rdata = (dbg_ack && !we_q) ? ram_rdata : dbg_rdata_q;

endmodule
